enet_nios_lcell_vector: RTL and testbench



---
 rtl/enet_nios_lcell_pkg.sv | 25 ++
 rtl/enet_nios_lcell_vector_if.sv | 28 ++
 rtl/enet_nios_lcell_lut4.sv | 15 +
 rtl/enet_nios_lcell_vector.sv | 125 ++++++++++++
 tb/tb_enet_nios_lcell_vector.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/enet_nios_lcell_pkg.sv
// Shared mode encoding and parameter-decode helpers for the logic-cell vector.
package enet_nios_lcell_pkg;

  typedef enum logic [0:0] {
    MODE_NORMAL  = 1'b0,
    MODE_COUNTER = 1'b1
  } lcell_mode_e;

  // Any string other than "normal" selects counter mode; bad strings are caught at elaboration.
  function automatic lcell_mode_e decode_mode(string mode);
    return (mode == "normal") ? MODE_NORMAL : MODE_COUNTER;
  endfunction

  // Register value after reset: zero, or the top count of the modulus when "high".
  function automatic logic [31:0] power_up_value(string power_up, longint unsigned modulus,
                                                 int unsigned width);
    longint unsigned v;
    v = 64'd0;
    if (power_up == "high") begin
      v = (modulus != 0) ? modulus - 64'd1 : (64'd1 << width) - 64'd1;
    end
    return v[31:0];
  endfunction

endpackage

// File: rtl/enet_nios_lcell_vector_if.sv
// Control, data and result signals of one logic-cell vector.
interface enet_nios_lcell_vector_if #(
  parameter int unsigned WIDTH = 8
);
  logic             ena;
  logic             sclr;
  logic             sload;
  logic             updown;
  logic             cin;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic [WIDTH-1:0] datac;
  logic [WIDTH-1:0] datad;
  logic [WIDTH-1:0] combout;
  logic [WIDTH-1:0] regout;
  logic             cout;
  logic             tc;

  modport master (
    output ena, sclr, sload, updown, cin, dataa, datab, datac, datad,
    input  combout, regout, cout, tc
  );

  modport slave (
    input  ena, sclr, sload, updown, cin, dataa, datab, datac, datad,
    output combout, regout, cout, tc
  );
endinterface

// File: rtl/enet_nios_lcell_lut4.sv
// Single-bit 4-input LUT; the mask is indexed by {d, c, b, a}.
module enet_nios_lcell_lut4 #(
  parameter logic [15:0] LutMask = 16'hFFFF
) (
  input  logic dataa_i,
  input  logic datab_i,
  input  logic datac_i,
  input  logic datad_i,
  output logic combout_o
);
  logic [3:0] sel;

  assign sel       = {datad_i, datac_i, datab_i, dataa_i};
  assign combout_o = LutMask[sel];
endmodule

// File: rtl/enet_nios_lcell_vector.sv
// WIDTH-bit logic-cell vector: per-bit 4-LUT or a loadable up/down modulo counter.
module enet_nios_lcell_vector
  import enet_nios_lcell_pkg::*;
#(
  parameter int unsigned     WIDTH          = 8,
  parameter string           OPERATION_MODE = "counter",
  parameter logic [15:0]     LUT_MASK       = 16'hFFFF,
  parameter longint unsigned MODULUS        = 0,
  parameter bit              CIN_USED       = 1'b0,
  parameter string           POWER_UP       = "low"
) (
  input logic                      clk,
  input logic                      reset_n,
  enet_nios_lcell_vector_if.slave  bus
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("enet_nios_lcell_vector: WIDTH must be 1..32");
  end
  if (MODULUS == 1 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("enet_nios_lcell_vector: MODULUS must be 0 or 2..2^WIDTH");
  end
  if (OPERATION_MODE != "normal" && OPERATION_MODE != "counter") begin : g_bad_mode
    $error("enet_nios_lcell_vector: OPERATION_MODE must be \"normal\" or \"counter\"");
  end
  if (POWER_UP != "low" && POWER_UP != "high") begin : g_bad_power_up
    $error("enet_nios_lcell_vector: POWER_UP must be \"low\" or \"high\"");
  end

  localparam lcell_mode_e     Mode        = decode_mode(OPERATION_MODE);
  localparam longint unsigned ModVal      = (MODULUS == 0) ? (64'd1 << WIDTH) : MODULUS;
  // Modulus and top count carried in WIDTH+1 bits so 2^WIDTH is representable.
  localparam logic [WIDTH:0]  ModM        = ModVal[WIDTH:0];
  localparam logic [WIDTH:0]  MaxExt      = ModM - 1'b1;
  localparam logic [31:0]     PowerUpFull = power_up_value(POWER_UP, MODULUS, WIDTH);
  localparam logic [WIDTH-1:0] PowerUp    = PowerUpFull[WIDTH-1:0];

  logic [WIDTH-1:0] regout_q, regout_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] lut_out;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] combout;
  logic [WIDTH:0]   load_ext;
  logic             step;
  logic             at_max;
  logic             at_zero;
  logic             cout;
  logic             unused_inputs;

  // Per-bit LUTs exist only in normal mode.
  if (Mode == MODE_NORMAL) begin : g_lut
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      enet_nios_lcell_lut4 #(
        .LutMask(LUT_MASK)
      ) u_lut4 (
        .dataa_i  (bus.dataa[i]),
        .datab_i  (bus.datab[i]),
        .datac_i  (bus.datac[i]),
        .datad_i  (bus.datad[i]),
        .combout_o(lut_out[i])
      );
    end
  end else begin : g_no_lut
    assign lut_out = '0;
  end

  assign step     = CIN_USED ? bus.cin : 1'b1;
  assign at_max   = ({1'b0, regout_q} == MaxExt);
  assign at_zero  = (regout_q == '0);
  // Constant modulus, so this reduces to a fixed reduction network.
  assign load_ext = {1'b0, bus.dataa} % ModM;

  // Counter next state assuming ena=1, in priority order clear, load, step, hold.
  always_comb begin
    cnt_next = regout_q;
    if (bus.sclr) begin
      cnt_next = '0;
    end else if (bus.sload) begin
      cnt_next = load_ext[WIDTH-1:0];
    end else if (step) begin
      if (bus.updown) begin
        cnt_next = at_max ? '0 : regout_q + 1'b1;
      end else begin
        cnt_next = at_zero ? MaxExt[WIDTH-1:0] : regout_q - 1'b1;
      end
    end
  end

  // Combinational outputs: mode-selected next value and the wrap indication.
  always_comb begin
    combout = (Mode == MODE_NORMAL) ? lut_out : cnt_next;
    cout    = (Mode == MODE_COUNTER) & bus.ena & step & ~bus.sclr & ~bus.sload &
              (bus.updown ? at_max : at_zero);
  end

  // Register next state; sclr also clears in normal mode, ena gates every update.
  always_comb begin
    regout_d = regout_q;
    tc_d     = cout;
    if (bus.ena) begin
      regout_d = bus.sclr ? '0 : combout;
    end
  end

  // Result and terminal-count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regout_q <= PowerUp;
      tc_q     <= 1'b0;
    end else begin
      regout_q <= regout_d;
      tc_q     <= tc_d;
    end
  end

  assign bus.combout = combout;
  assign bus.regout  = regout_q;
  assign bus.cout    = cout;
  assign bus.tc      = tc_q;

  // Inputs that only matter in some configurations.
  assign unused_inputs = ^{bus.datab, bus.datac, bus.datad, bus.cin, load_ext[WIDTH]};

endmodule

// File: tb/tb_enet_nios_lcell_vector.sv
// Self-checking bench: four configurations of the vector against a modular-arithmetic model.
module tb_enet_nios_lcell_vector;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  enet_nios_lcell_vector_if #(.WIDTH(4)) if_n ();
  enet_nios_lcell_vector_if #(.WIDTH(4)) if_a ();
  enet_nios_lcell_vector_if #(.WIDTH(8)) if_d ();
  enet_nios_lcell_vector_if #(.WIDTH(4)) if_c ();

  enet_nios_lcell_vector #(
    .WIDTH(4), .OPERATION_MODE("normal"), .LUT_MASK(16'h8000)
  ) u_norm (.clk(clk), .reset_n(reset_n), .bus(if_n));

  enet_nios_lcell_vector #(
    .WIDTH(4), .OPERATION_MODE("counter"), .MODULUS(10)
  ) u_mod10 (.clk(clk), .reset_n(reset_n), .bus(if_a));

  enet_nios_lcell_vector #(
    .WIDTH(8), .OPERATION_MODE("counter"), .MODULUS(0), .POWER_UP("high")
  ) u_down (.clk(clk), .reset_n(reset_n), .bus(if_d));

  enet_nios_lcell_vector #(
    .WIDTH(4), .OPERATION_MODE("counter"), .MODULUS(10), .CIN_USED(1'b1)
  ) u_cin (.clk(clk), .reset_n(reset_n), .bus(if_c));

  // Reference counter: next value in Z/m.
  function automatic int unsigned ref_next(int unsigned m, int unsigned cur, bit sclr, bit sload,
                                           bit stp, bit up, int unsigned a);
    if (sclr) return 0;
    if (sload) return a % m;
    if (!stp) return cur;
    return up ? (cur + 1) % m : (cur + m - 1) % m;
  endfunction

  function automatic bit ref_cout(int unsigned m, int unsigned cur, bit ena, bit sclr, bit sload,
                                  bit stp, bit up);
    return ena && stp && !sclr && !sload && (up ? (cur == m - 1) : (cur == 0));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {if_n.ena, if_n.sclr, if_n.sload, if_n.updown, if_n.cin} = '0;
    {if_a.ena, if_a.sclr, if_a.sload, if_a.updown, if_a.cin} = '0;
    {if_d.ena, if_d.sclr, if_d.sload, if_d.updown, if_d.cin} = '0;
    {if_c.ena, if_c.sclr, if_c.sload, if_c.updown, if_c.cin} = '0;
    {if_n.dataa, if_n.datab, if_n.datac, if_n.datad} = '0;
    {if_a.dataa, if_a.datab, if_a.datac, if_a.datad} = '0;
    {if_d.dataa, if_d.datab, if_d.datac, if_d.datad} = '0;
    {if_c.dataa, if_c.datab, if_c.datac, if_c.datad} = '0;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    #12;
    checks++; if (if_n.regout !== 4'h0) begin errors++;
      $display("FAIL reset_norm_regout got=%h exp=0", if_n.regout); end
    checks++; if (if_a.regout !== 4'h0) begin errors++;
      $display("FAIL reset_mod10_regout got=%h exp=0", if_a.regout); end
    checks++; if (if_d.regout !== 8'hFF) begin errors++;
      $display("FAIL reset_down_regout got=%h exp=ff", if_d.regout); end
    checks++; if ({if_n.tc, if_a.tc, if_d.tc, if_c.tc} !== 4'b0000) begin errors++;
      $display("FAIL reset_tc got=%b exp=0000", {if_n.tc, if_a.tc, if_d.tc, if_c.tc}); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_normal();
    logic [15:0] mask;
    logic [3:0]  exp_q;
    logic [3:0]  exp_c;
    logic [3:0]  idx;
    mask = 16'h8000;
    if_n.ena = 1'b1;
    {if_n.dataa, if_n.datab, if_n.datac, if_n.datad} = {4{4'hF}};
    #1;
    checks++; if (if_n.combout !== 4'hF) begin errors++;
      $display("FAIL norm_comb_all1 got=%h exp=f", if_n.combout); end
    tick();
    checks++; if (if_n.regout !== 4'hF) begin errors++;
      $display("FAIL norm_reg_all1 got=%h exp=f", if_n.regout); end
    if_n.dataa = 4'h0;
    #1;
    checks++; if (if_n.combout !== 4'h0 || if_n.regout !== 4'hF) begin errors++;
      $display("FAIL norm_comb_a0 got=%h/%h exp=0/f", if_n.combout, if_n.regout); end
    tick();
    checks++; if (if_n.regout !== 4'h0) begin errors++;
      $display("FAIL norm_reg_a0 got=%h exp=0", if_n.regout); end
    exp_q = 4'h0;
    for (int n = 0; n < 40; n++) begin
      if_n.ena    = ($urandom_range(0, 3) != 0);
      if_n.sclr   = ($urandom_range(0, 4) == 0);
      if_n.sload  = $urandom_range(0, 1);
      if_n.updown = $urandom_range(0, 1);
      // Bias toward all-ones so the single set mask entry is hit often.
      if_n.dataa = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
      if_n.datab = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
      if_n.datac = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
      if_n.datad = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
      for (int b = 0; b < 4; b++) begin
        idx      = {if_n.datad[b], if_n.datac[b], if_n.datab[b], if_n.dataa[b]};
        exp_c[b] = mask[idx];
      end
      #1;
      checks++; if (if_n.combout !== exp_c || if_n.cout !== 1'b0) begin errors++;
        $display("FAIL norm_rand_comb got=%h/%b exp=%h/0", if_n.combout, if_n.cout, exp_c); end
      if (if_n.ena) exp_q = if_n.sclr ? 4'h0 : exp_c;
      tick();
      checks++; if (if_n.regout !== exp_q || if_n.tc !== 1'b0) begin errors++;
        $display("FAIL norm_rand_reg got=%h/%b exp=%h/0", if_n.regout, if_n.tc, exp_q); end
    end
    idle();
  endtask

  task automatic test_mod10_up();
    if_a.ena = 1'b1;
    if_a.updown = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (if_a.regout !== 4'(i) || if_a.cout !== (i == 9)) begin errors++;
        $display("FAIL mod10_seq got=%h/%b exp=%h/%b", if_a.regout, if_a.cout, 4'(i), i == 9); end
      tick();
    end
    checks++; if (if_a.regout !== 4'h0 || if_a.tc !== 1'b1) begin errors++;
      $display("FAIL mod10_wrap got=%h/%b exp=0/1", if_a.regout, if_a.tc); end
    tick();
    checks++; if (if_a.regout !== 4'h1 || if_a.tc !== 1'b0) begin errors++;
      $display("FAIL mod10_tc_pulse got=%h/%b exp=1/0", if_a.regout, if_a.tc); end
    idle();
  endtask

  task automatic test_down();
    if_d.ena = 1'b1;
    if_d.updown = 1'b0;
    #1;
    checks++; if (if_d.regout !== 8'hFF || if_d.cout !== 1'b0) begin errors++;
      $display("FAIL down_start got=%h/%b exp=ff/0", if_d.regout, if_d.cout); end
    tick();
    checks++; if (if_d.regout !== 8'hFE) begin errors++;
      $display("FAIL down_1 got=%h exp=fe", if_d.regout); end
    tick();
    checks++; if (if_d.regout !== 8'hFD) begin errors++;
      $display("FAIL down_2 got=%h exp=fd", if_d.regout); end
    if_d.sload = 1'b1;
    if_d.dataa = 8'h00;
    tick();
    if_d.sload = 1'b0;
    #1;
    checks++; if (if_d.regout !== 8'h00 || if_d.cout !== 1'b1) begin errors++;
      $display("FAIL down_load0 got=%h/%b exp=00/1", if_d.regout, if_d.cout); end
    tick();
    checks++; if (if_d.regout !== 8'hFF || if_d.tc !== 1'b1) begin errors++;
      $display("FAIL down_wrap got=%h/%b exp=ff/1", if_d.regout, if_d.tc); end
    tick();
    checks++; if (if_d.regout !== 8'hFE || if_d.tc !== 1'b0) begin errors++;
      $display("FAIL down_tc_pulse got=%h/%b exp=fe/0", if_d.regout, if_d.tc); end
    idle();
  endtask

  task automatic test_priority();
    if_a.ena = 1'b1; if_a.updown = 1'b1; if_a.sload = 1'b1; if_a.dataa = 4'd9;
    tick();
    if_a.sclr = 1'b1; if_a.dataa = 4'd5;
    #1;
    checks++; if (if_a.regout !== 4'd9 || if_a.cout !== 1'b0 || if_a.combout !== 4'd0) begin
      errors++;
      $display("FAIL prio_comb got=%h/%b/%h exp=9/0/0", if_a.regout, if_a.cout, if_a.combout);
    end
    tick();
    checks++; if (if_a.regout !== 4'd0) begin errors++;
      $display("FAIL prio_sclr got=%h exp=0", if_a.regout); end
    if_a.sclr = 1'b0; if_a.dataa = 4'd9;
    tick();
    if_a.ena = 1'b0; if_a.sclr = 1'b1; if_a.dataa = 4'd5;
    tick();
    checks++; if (if_a.regout !== 4'd9) begin errors++;
      $display("FAIL prio_ena_hold got=%h exp=9", if_a.regout); end
    if_a.ena = 1'b1; if_a.sclr = 1'b0; if_a.dataa = 4'd3;
    #1;
    checks++; if (if_a.cout !== 1'b0) begin errors++;
      $display("FAIL prio_wrap_load_cout got=%b exp=0", if_a.cout); end
    tick();
    checks++; if (if_a.regout !== 4'd3 || if_a.tc !== 1'b0) begin errors++;
      $display("FAIL prio_wrap_load got=%h/%b exp=3/0", if_a.regout, if_a.tc); end
    idle();
  endtask

  task automatic test_cin();
    logic [3:0] cin_seq [4];
    logic [3:0] exp_seq [4];
    cin_seq = '{4'd1, 4'd0, 4'd1, 4'd1};
    exp_seq = '{4'd1, 4'd1, 4'd2, 4'd3};
    if_c.ena = 1'b1;
    if_c.updown = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_c.cin = cin_seq[i][0];
      tick();
      checks++; if (if_c.regout !== exp_seq[i]) begin errors++;
        $display("FAIL cin_step%0d got=%h exp=%h", i, if_c.regout, exp_seq[i]); end
    end
    if_c.cin = 1'b0; if_c.sload = 1'b1; if_c.dataa = 4'd12;
    tick();
    checks++; if (if_c.regout !== 4'd2) begin errors++;
      $display("FAIL cin_load12 got=%h exp=2", if_c.regout); end
    idle();
  endtask

  task automatic test_random_counters();
    int unsigned ec, ed, nc, nd;
    bit tcc, tcd;
    if_c.ena = 1'b1; if_c.sclr = 1'b1;
    if_d.ena = 1'b1; if_d.sclr = 1'b1;
    tick();
    ec = 0; ed = 0; tcc = 1'b0; tcd = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if_c.ena = ($urandom_range(0, 3) != 0);  if_d.ena = ($urandom_range(0, 3) != 0);
      if_c.sclr = ($urandom_range(0, 15) == 0); if_d.sclr = ($urandom_range(0, 15) == 0);
      if_c.sload = ($urandom_range(0, 7) == 0); if_d.sload = ($urandom_range(0, 7) == 0);
      if_c.updown = $urandom_range(0, 1);      if_d.updown = ($urandom_range(0, 3) != 0);
      if_c.cin = $urandom_range(0, 1);         if_d.cin = $urandom_range(0, 1);
      if_c.dataa = 4'($urandom);
      if_d.dataa = ($urandom_range(0, 1) != 0) ? 8'($urandom) :
                   (($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF);
      nc = ref_next(10, ec, if_c.sclr, if_c.sload, if_c.cin, if_c.updown, 32'(if_c.dataa));
      nd = ref_next(256, ed, if_d.sclr, if_d.sload, 1'b1, if_d.updown, 32'(if_d.dataa));
      #1;
      checks++; if (if_c.combout !== 4'(nc) ||
                    if_c.cout !== ref_cout(10, ec, if_c.ena, if_c.sclr, if_c.sload, if_c.cin,
                                           if_c.updown)) begin errors++;
        $display("FAIL rand_cin_comb got=%h/%b exp=%h", if_c.combout, if_c.cout, 4'(nc)); end
      checks++; if (if_d.combout !== 8'(nd) ||
                    if_d.cout !== ref_cout(256, ed, if_d.ena, if_d.sclr, if_d.sload, 1'b1,
                                           if_d.updown)) begin errors++;
        $display("FAIL rand_down_comb got=%h/%b exp=%h", if_d.combout, if_d.cout, 8'(nd)); end
      tcc = ref_cout(10, ec, if_c.ena, if_c.sclr, if_c.sload, if_c.cin, if_c.updown);
      tcd = ref_cout(256, ed, if_d.ena, if_d.sclr, if_d.sload, 1'b1, if_d.updown);
      if (if_c.ena) ec = nc;
      if (if_d.ena) ed = nd;
      tick();
      checks++; if (if_c.regout !== 4'(ec) || if_c.tc !== tcc) begin errors++;
        $display("FAIL rand_cin_reg got=%h/%b exp=%h/%b", if_c.regout, if_c.tc, 4'(ec), tcc); end
      checks++; if (if_d.regout !== 8'(ed) || if_d.tc !== tcd) begin errors++;
        $display("FAIL rand_down_reg got=%h/%b exp=%h/%b", if_d.regout, if_d.tc, 8'(ed), tcd); end
    end
    idle();
  endtask

  task automatic test_async_reset();
    if_a.ena = 1'b1; if_a.updown = 1'b1; if_a.sload = 1'b1; if_a.dataa = 4'd7;
    if_d.ena = 1'b1; if_d.updown = 1'b0; if_d.sload = 1'b1; if_d.dataa = 8'd7;
    tick();
    if_a.sload = 1'b0; if_d.sload = 1'b0;
    checks++; if (if_a.regout !== 4'd7 || if_d.regout !== 8'd7) begin errors++;
      $display("FAIL arst_pre got=%h/%h exp=7/07", if_a.regout, if_d.regout); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (if_a.regout !== 4'd0 || if_a.tc !== 1'b0) begin errors++;
      $display("FAIL arst_mod10 got=%h/%b exp=0/0", if_a.regout, if_a.tc); end
    checks++; if (if_d.regout !== 8'hFF || if_d.tc !== 1'b0) begin errors++;
      $display("FAIL arst_down got=%h/%b exp=ff/0", if_d.regout, if_d.tc); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (if_a.regout !== 4'd1 || if_d.regout !== 8'hFE) begin errors++;
      $display("FAIL arst_resume got=%h/%h exp=1/fe", if_a.regout, if_d.regout); end
    idle();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_mod10_up();
    test_down();
    test_priority();
    test_cin();
    test_random_counters();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
